// File: rtl/i2c_txn_decode.sv
// Transaction-level decoder for the i2c_listen byte stream: tracks address, direction, offset and data.
// Define I2C_TXN_STATS_EN to add the saturating 16-bit match_count write-match counter.
module i2c_txn_decode #(
  parameter logic [6:0] DEV_ADDR = 7'h4A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  byte_in,
  input  logic        byte_ready,
  input  logic        sop,
  input  logic        eot,
  input  logic [7:0]  match_reg,
  output logic        rw,
  output logic [7:0]  reg_offset,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        write_match,
  output logic [7:0]  pkt_len,
  output logic        pkt_done,
  output logic        addr_err
`ifdef I2C_TXN_STATS_EN
  ,
  output logic [15:0] match_count
`endif
);

  // Handshake: no backpressure anywhere. byte_in is valid only in the cycle byte_ready is high;
  // sop/eot are single-cycle pulses; data_valid/write_match/pkt_done are single-cycle valids with no ready.

  typedef enum logic [2:0] {IDLE, ADDR, REG, DATA, SKIP} state_t;

  state_t     state;
  logic [7:0] count;
  logic [7:0] offset_ptr;

  logic [7:0] data_byte;
  logic       nack;
  logic       addr_hit;
  logic       take_byte;
  logic [7:0] count_inc;
  logic [7:0] count_next;

  assign data_byte  = byte_in[8:1];
  assign nack       = byte_in[0];
  assign addr_hit   = (byte_in[8:2] == DEV_ADDR);
  assign take_byte  = byte_ready && (state != IDLE);
  assign count_inc  = (count == 8'hFF) ? 8'hFF : count + 8'd1;
  // A byte arriving with eot is counted before the packet length is flushed.
  assign count_next = take_byte ? count_inc : count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= 8'd0;
      offset_ptr  <= 8'd0;
      rw          <= 1'b0;
      reg_offset  <= 8'd0;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      write_match <= 1'b0;
      pkt_len     <= 8'd0;
      pkt_done    <= 1'b0;
      addr_err    <= 1'b0;
`ifdef I2C_TXN_STATS_EN
      match_count <= 16'd0;
`endif
    end else begin
      data_valid  <= 1'b0;
      write_match <= 1'b0;
      pkt_done    <= 1'b0;
      // sop discards a coincident byte; sop with eot collapses to a single flush.
      if (sop) begin
        if (state != IDLE) begin
          pkt_len  <= count;
          pkt_done <= 1'b1;
        end
        state <= ADDR;
        count <= 8'd0;
      end else begin
        count <= count_next;
        if (take_byte) begin
          case (state)
            ADDR: begin
              if (addr_hit && !nack) begin
                rw    <= byte_in[1];
                state <= byte_in[1] ? DATA : REG;
              end else begin
                if (addr_hit) addr_err <= 1'b1;
                state <= SKIP;
              end
            end
            REG: begin
              offset_ptr <= data_byte;
              state      <= DATA;
            end
            DATA: begin
              data_out   <= data_byte;
              reg_offset <= offset_ptr;
              data_valid <= 1'b1;
              offset_ptr <= offset_ptr + 8'd1;
              if (!rw && (offset_ptr == match_reg)) begin
                write_match <= 1'b1;
`ifdef I2C_TXN_STATS_EN
                if (match_count != 16'hFFFF) match_count <= match_count + 16'd1;
`endif
              end
              if (nack) state <= SKIP;
            end
            default: ;
          endcase
        end
        if (eot && (state != IDLE)) begin
          pkt_len  <= count_next;
          pkt_done <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end

endmodule
